// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and sequencer state encoding for the Viterbi controller
package viterbi_pkg;
    localparam int NUM_STATES = 64;
    localparam int ST_W       = 6;
    localparam int TB_DEPTH   = 32;
    localparam int PTR_W      = 6;
    localparam int SYM_W      = 3;
    typedef enum logic [2:0] {IDLE, ACS, COMMIT, TB, OUT} seq_state_t;
endpackage

// File: rtl/vit_tb_walker.sv
// vit_tb_walker: walks the survivor history backwards one column per step and flags the last step
module vit_tb_walker #(
    parameter int ST_W     = viterbi_pkg::ST_W,
    parameter int PTR_W    = viterbi_pkg::PTR_W,
    parameter int TB_DEPTH = viterbi_pkg::TB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             bit_in,
    input  logic [PTR_W-1:0] load_ptr,
    input  logic [ST_W-1:0]  load_state,
    output logic [PTR_W-1:0] ptr,
    output logic [ST_W-1:0]  state,
    output logic             done
);
    logic [PTR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d;
    logic [ST_W-1:0]  state_q, state_d;

    // load a fresh walk, or shift the survivor bit into the state and move to the previous column
    always_comb begin
        ptr_d   = load ? load_ptr : step ? ptr_q - PTR_W'(1) : ptr_q;
        cnt_d   = load ? PTR_W'(TB_DEPTH) : step ? cnt_q - PTR_W'(1) : cnt_q;
        state_d = load ? load_state : step ? {state_q[ST_W-2:0], bit_in} : state_q;
    end

    // walker registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign ptr   = ptr_q;
    assign state = state_q;
    assign done  = cnt_q == PTR_W'(1);
endmodule

// File: rtl/viterbi_seq_ctrl.sv
// viterbi_seq_ctrl: per-symbol ACS sweep, metric-bank commit, traceback and decoded-bit handshake
module viterbi_seq_ctrl #(
    parameter int NUM_STATES = viterbi_pkg::NUM_STATES,
    parameter int ST_W       = viterbi_pkg::ST_W,
    parameter int TB_DEPTH   = viterbi_pkg::TB_DEPTH,
    parameter int PTR_W      = viterbi_pkg::PTR_W,
    parameter int SYM_W      = viterbi_pkg::SYM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             clear,
    output logic             acs_en,
    output logic [ST_W-1:0]  acs_state,
    output logic [SYM_W-1:0] acs_sym,
    output logic             bank_swap,
    output logic [PTR_W-1:0] wr_ptr,
    input  logic [ST_W-1:0]  best_state,
    output logic             tb_en,
    output logic [PTR_W-1:0] tb_ptr,
    output logic [ST_W-1:0]  tb_state,
    input  logic             tb_bit_in,
    output logic             dec_valid,
    output logic             dec_bit,
    input  logic             dec_ready
);
    import viterbi_pkg::*;

    seq_state_t       state_q, state_d;
    logic             sym_ready_q, sym_ready_d, acs_en_q, acs_en_d, bank_swap_q, bank_swap_d;
    logic             tb_en_q, tb_en_d, dec_valid_q, dec_valid_d, dec_bit_q, dec_bit_d;
    logic [ST_W-1:0]  acs_state_q, acs_state_d;
    logic [SYM_W-1:0] acs_sym_q, acs_sym_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, fill_q, fill_d, fill_inc;
    logic             tb_load, tb_done;

    // fill saturates so every symbol past the first window produces exactly one bit
    assign fill_inc = (fill_q == PTR_W'(TB_DEPTH)) ? fill_q : fill_q + PTR_W'(1);

    // next-state and next-output logic; all outputs are registered copies of these
    always_comb begin
        state_d     = state_q;
        sym_ready_d = sym_ready_q;
        acs_en_d    = acs_en_q;
        acs_state_d = acs_state_q;
        acs_sym_d   = acs_sym_q;
        bank_swap_d = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        tb_en_d     = tb_en_q;
        dec_valid_d = dec_valid_q;
        dec_bit_d   = dec_bit_q;
        tb_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    fill_d   = '0;
                    wr_ptr_d = '0;
                end else if (sym_valid) begin
                    acs_sym_d   = sym_data;
                    acs_state_d = '0;
                    acs_en_d    = 1'b1;
                    sym_ready_d = 1'b0;
                    state_d     = ACS;
                end
            end
            ACS: begin
                if (acs_state_q == ST_W'(NUM_STATES - 1)) begin
                    acs_en_d    = 1'b0;
                    bank_swap_d = 1'b1;
                    state_d     = COMMIT;
                end else begin
                    acs_state_d = acs_state_q + ST_W'(1);
                end
            end
            COMMIT: begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                fill_d   = fill_inc;
                if (fill_inc == PTR_W'(TB_DEPTH)) begin
                    tb_load = 1'b1;
                    tb_en_d = 1'b1;
                    state_d = TB;
                end else begin
                    sym_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            TB: begin
                if (tb_done) begin
                    tb_en_d     = 1'b0;
                    dec_bit_d   = tb_bit_in;
                    dec_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (dec_ready) begin
                    dec_valid_d = 1'b0;
                    sym_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sym_ready_q <= 1'b1;
            acs_en_q    <= 1'b0;
            acs_state_q <= '0;
            acs_sym_q   <= '0;
            bank_swap_q <= 1'b0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            tb_en_q     <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_ready_q <= sym_ready_d;
            acs_en_q    <= acs_en_d;
            acs_state_q <= acs_state_d;
            acs_sym_q   <= acs_sym_d;
            bank_swap_q <= bank_swap_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            tb_en_q     <= tb_en_d;
            dec_valid_q <= dec_valid_d;
            dec_bit_q   <= dec_bit_d;
        end
    end

    vit_tb_walker #(.ST_W(ST_W), .PTR_W(PTR_W), .TB_DEPTH(TB_DEPTH)) u_walker (
        .clk        (clk),
        .rst        (rst),
        .load       (tb_load),
        .step       (tb_en_q),
        .bit_in     (tb_bit_in),
        .load_ptr   (wr_ptr_q),
        .load_state (best_state),
        .ptr        (tb_ptr),
        .state      (tb_state),
        .done       (tb_done)
    );

    assign sym_ready = sym_ready_q;
    assign acs_en    = acs_en_q;
    assign acs_state = acs_state_q;
    assign acs_sym   = acs_sym_q;
    assign bank_swap = bank_swap_q;
    assign wr_ptr    = wr_ptr_q;
    assign tb_en     = tb_en_q;
    assign dec_valid = dec_valid_q;
    assign dec_bit   = dec_bit_q;
endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// tb_viterbi_seq_ctrl: randomized symbol stream against a transaction-level model of the sequencer
module tb_viterbi_seq_ctrl;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int TD = 3;
    localparam int PW = 3;
    localparam int YW = 3;
    localparam int HIST = 1 << PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sym_valid = 1'b0;
    logic [YW-1:0] sym_data = '0;
    logic          clear = 1'b0;
    logic [SW-1:0] best_state = '0;
    logic          dec_ready = 1'b0;
    logic          sym_ready, acs_en, bank_swap, tb_en, tb_bit_in, dec_valid, dec_bit;
    logic [SW-1:0] acs_state, tb_state;
    logic [YW-1:0] acs_sym;
    logic [PW-1:0] wr_ptr, tb_ptr;
    logic          surv [HIST][NS];

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;
    int m_fill  = 0;

    always #5 clk = ~clk;

    assign tb_bit_in = surv[tb_ptr][tb_state];

    viterbi_seq_ctrl #(.NUM_STATES(NS), .ST_W(SW), .TB_DEPTH(TD), .PTR_W(PW), .SYM_W(YW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .clear      (clear),
        .acs_en     (acs_en),
        .acs_state  (acs_state),
        .acs_sym    (acs_sym),
        .bank_swap  (bank_swap),
        .wr_ptr     (wr_ptr),
        .best_state (best_state),
        .tb_en      (tb_en),
        .tb_ptr     (tb_ptr),
        .tb_state   (tb_state),
        .tb_bit_in  (tb_bit_in),
        .dec_valid  (dec_valid),
        .dec_bit    (dec_bit),
        .dec_ready  (dec_ready)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_rst();
        chk("rst_sym_ready", sym_ready, 1);
        chk("rst_acs_en", acs_en, 0);
        chk("rst_acs_state", acs_state, 0);
        chk("rst_acs_sym", acs_sym, 0);
        chk("rst_bank_swap", bank_swap, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_tb_en", tb_en, 0);
        chk("rst_tb_ptr", tb_ptr, 0);
        chk("rst_tb_state", tb_state, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_bit", dec_bit, 0);
    endtask

    task automatic rand_surv();
        for (int i = 0; i < HIST; i++)
            for (int j = 0; j < NS; j++)
                surv[i][j] = 1'($urandom_range(0, 1));
    endtask

    // one full symbol transaction; hold = extra cycles of dec_ready=0 in the output phase
    task automatic do_symbol(input int s, input int best, input int hold);
        int col, st, p, b;
        chk("idle_ready", sym_ready, 1);
        sym_valid  = 1'b1;
        sym_data   = YW'(s);
        best_state = SW'(best);
        @(posedge clk); #1;
        sym_valid = 1'b0;
        sym_data  = YW'($urandom);
        for (int i = 0; i < NS; i++) begin
            chk("acs_en", acs_en, 1);
            chk("acs_state", acs_state, i);
            chk("acs_sym", acs_sym, s);
            chk("acs_sym_ready", sym_ready, 0);
            chk("acs_bank_swap", bank_swap, 0);
            @(posedge clk); #1;
        end
        chk("commit_bank_swap", bank_swap, 1);
        chk("commit_acs_en", acs_en, 0);
        chk("commit_wr_ptr", wr_ptr, m_ptr);
        col    = m_ptr;
        m_ptr  = (m_ptr + 1) % HIST;
        m_fill = (m_fill < TD) ? m_fill + 1 : TD;
        @(posedge clk); #1;
        chk("wr_ptr_adv", wr_ptr, m_ptr);
        chk("bank_swap_pulse", bank_swap, 0);
        if (m_fill == TD) begin
            st = best;
            p  = col;
            b  = 0;
            for (int k = 0; k < TD; k++) begin
                chk("tb_en", tb_en, 1);
                chk("tb_ptr", tb_ptr, p);
                chk("tb_state", tb_state, st);
                chk("tb_dec_valid", dec_valid, 0);
                b  = surv[p][st];
                st = ((st << 1) | b) % NS;
                p  = (p + HIST - 1) % HIST;
                @(posedge clk); #1;
            end
            chk("out_tb_en", tb_en, 0);
            chk("out_dec_valid", dec_valid, 1);
            chk("out_dec_bit", dec_bit, b);
            chk("out_sym_ready", sym_ready, 0);
            for (int h = 0; h < hold; h++) begin
                sym_valid = 1'b1;
                sym_data  = YW'($urandom);
                @(posedge clk); #1;
                chk("hold_dec_valid", dec_valid, 1);
                chk("hold_dec_bit", dec_bit, b);
                chk("hold_sym_ready", sym_ready, 0);
                chk("hold_acs_en", acs_en, 0);
                chk("hold_acs_sym", acs_sym, s);
            end
            sym_valid = 1'b0;
            dec_ready = 1'b1;
            @(posedge clk); #1;
            dec_ready = 1'b0;
            chk("rel_dec_valid", dec_valid, 0);
            chk("rel_sym_ready", sym_ready, 1);
            chk("rel_acs_en", acs_en, 0);
        end else begin
            chk("nofill_tb_en", tb_en, 0);
            chk("nofill_dec_valid", dec_valid, 0);
            chk("nofill_sym_ready", sym_ready, 1);
        end
    endtask

    task automatic do_clear(input bit with_valid);
        clear     = 1'b1;
        sym_valid = with_valid;
        sym_data  = YW'($urandom);
        @(posedge clk); #1;
        clear     = 1'b0;
        sym_valid = 1'b0;
        m_ptr     = 0;
        m_fill    = 0;
        chk("clear_acs_en", acs_en, 0);
        chk("clear_wr_ptr", wr_ptr, 0);
        chk("clear_sym_ready", sym_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rand_surv();
        @(posedge clk); #1;
        chk_rst();
        rst = 1'b0;
        @(posedge clk); #1;
        // single symbol, no traceback yet
        do_symbol(5, 0, 0);
        // window fills on the third symbol; directed traceback path 2 -> 1 -> 2
        do_symbol(int'($urandom_range(0, 7)), int'($urandom_range(0, NS - 1)), 0);
        rand_surv();
        surv[2][2] = 1'b1;
        surv[1][1] = 1'b0;
        surv[0][2] = 1'b1;
        do_symbol(int'($urandom_range(0, 7)), 2, 0);
        chk("directed_dec_bit", dec_bit, 1);
        // pointer wrap with one decoded bit per symbol
        for (int i = 0; i < 8; i++) begin
            rand_surv();
            do_symbol(int'($urandom_range(0, 7)), int'($urandom_range(0, NS - 1)), 0);
        end
        // long backpressure
        rand_surv();
        do_symbol(int'($urandom_range(0, 7)), int'($urandom_range(0, NS - 1)), 10);
        // random stream with random backpressure and occasional clears
        for (int i = 0; i < 20; i++) begin
            rand_surv();
            if ($urandom_range(0, 7) == 0) do_clear(1'($urandom_range(0, 1)));
            do_symbol(int'($urandom_range(0, 7)), int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 3)));
        end
        // clear beats a simultaneous symbol with fill=2
        do_clear(1'b0);
        do_symbol(1, 0, 0);
        do_symbol(2, 1, 0);
        do_clear(1'b1);
        do_symbol(3, 2, 0);
        do_symbol(4, 3, 0);
        // reset during the second traceback cycle
        rand_surv();
        sym_valid = 1'b1;
        sym_data  = 3'd6;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        repeat (NS + 2) @(posedge clk);
        #1;
        chk("pre_rst_tb_en", tb_en, 1);
        #2 rst = 1'b1;
        #1;
        chk_rst();
        @(posedge clk); #1;
        rst    = 1'b0;
        m_ptr  = 0;
        m_fill = 0;
        @(posedge clk); #1;
        chk("post_rst_dec_valid", dec_valid, 0);
        do_symbol(7, 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/viterbi_seq_ctrl.md
Name: viterbi_seq_ctrl

Overview:
Sequencer for the Viterbi decoder core. It accepts one received symbol at a time and steps the add-compare-select (ACS) unit through every trellis state. It then commits the path-metric bank and advances the survivor-history write pointer, a 6-bit wrap-around counter. Once the history window holds TB_DEPTH steps, it runs a traceback over survivor memory and emits one decoded bit per symbol through a valid/ready handshake.

Parameters:
NUM_STATES, 64, number of trellis states (2^ST_W); K=7 code
ST_W, 6, state-index width
TB_DEPTH, 32, traceback depth in trellis steps; must satisfy 1 <= TB_DEPTH <= 2^PTR_W - 1
PTR_W, 6, survivor-history pointer width (history depth 2^PTR_W)
SYM_W, 3, soft-symbol width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
sym_valid  in  1  input symbol valid
sym_data  in  SYM_W  received soft symbol
sym_ready  out  1  controller can accept a symbol
clear  in  1  synchronous window clear; sampled only in IDLE
acs_en  out  1  ACS unit enable
acs_state  out  ST_W  state index being updated
acs_sym  out  SYM_W  latched symbol for ACS
bank_swap  out  1  one-cycle pulse: swap old/new path-metric banks
wr_ptr  out  PTR_W  survivor-history write column
best_state  in  ST_W  minimum-metric state; valid in the COMMIT cycle
tb_en  out  1  survivor-memory read enable
tb_ptr  out  PTR_W  survivor column being read
tb_state  out  ST_W  state row being read
tb_bit_in  in  1  survivor bit at (tb_ptr, tb_state); combinational read
dec_valid  out  1  decoded bit valid
dec_bit  out  1  decoded bit
dec_ready  in  1  downstream accepts decoded bit

Behaviour:
- Reset (async, rst=1): FSM enters IDLE.
- Reset values: sym_ready=1; acs_en=0, acs_state=0, acs_sym=0; bank_swap=0; wr_ptr=0; tb_en=0, tb_ptr=0, tb_state=0; dec_valid=0, dec_bit=0; fill count=0.
- Reset mid-operation aborts any ACS sweep, traceback or pending output with no residual pulse.
- FSM has five states: IDLE, ACS, COMMIT, TB, OUT.
- IDLE:
  - sym_ready=1.
  - clear=1 takes priority over sym_valid: fill<=0, wr_ptr<=0, symbol not accepted that cycle.
  - Otherwise sym_valid=1: latch sym_data into acs_sym, set acs_state<=0, go to ACS.
- ACS:
  - acs_en=1 for exactly NUM_STATES cycles; acs_state increments 0..NUM_STATES-1.
  - After the cycle with acs_state=NUM_STATES-1, go to COMMIT.
  - sym_ready=0; sym_valid is ignored.
- COMMIT (1 cycle):
  - bank_swap=1; wr_ptr<=wr_ptr+1 mod 2^PTR_W; fill<=min(fill+1, TB_DEPTH).
  - If the new fill equals TB_DEPTH: tb_state<=best_state, tb_ptr<=wr_ptr (the column just written), go to TB. Otherwise go to IDLE.
- TB:
  - tb_en=1 for exactly TB_DEPTH cycles.
  - Each cycle: tb_state<={tb_state[ST_W-2:0], tb_bit_in}; tb_ptr<=tb_ptr-1 mod 2^PTR_W (wraps 0 to 2^PTR_W-1).
  - In the final cycle, register dec_bit<=tb_bit_in and go to OUT.
- OUT:
  - dec_valid=1 with dec_bit stable until dec_ready=1; then go to IDLE.
  - Backpressure holds the FSM in OUT; sym_ready stays 0.
- Latency:
  - Symbol acceptance to bank_swap: NUM_STATES+1 cycles.
  - Once the window is full, acceptance to dec_valid: NUM_STATES+TB_DEPTH+2 cycles.
  - Minimum symbol period when full: NUM_STATES+TB_DEPTH+3 cycles.
- Fill saturates at TB_DEPTH, so every symbol after the first TB_DEPTH-1 produces exactly one decoded bit. The first TB_DEPTH-1 symbols produce none.
- wr_ptr wraps freely; TB_DEPTH < 2^PTR_W guarantees traceback never reads an overwritten column.
- clear and sym_valid are ignored outside IDLE.

Decomposition:
- Shared package viterbi_pkg holds: FSM state enum (IDLE, ACS, COMMIT, TB, OUT); constants NUM_STATES, ST_W, TB_DEPTH, PTR_W, SYM_W.
- One natural sub-module: vit_tb_walker, holding tb_ptr, tb_state and the TB_DEPTH down-counter. It takes load/step inputs and produces a done output.

Test Plan:
Small configuration for all scenarios: NUM_STATES=4, ST_W=2, TB_DEPTH=3, PTR_W=3.
1. Reset, then one symbol 3'b101 -> acs_en high 4 cycles with acs_state 0,1,2,3 and acs_sym=5; bank_swap at cycle 5; wr_ptr=1; no tb_en; sym_ready returns 1.
2. Three symbols back-to-back -> no dec_valid after symbols 1-2. After symbol 3, tb_en high 3 cycles with tb_ptr 2,1,0. With best_state=2 and tb_bit_in=1,0,1, tb_state goes 2,1,2; dec_bit=1.
3. Eight more symbols -> wr_ptr wraps 7 to 0. Traceback starting at tb_ptr=1 reads 1,0,7. One dec_valid per symbol.
4. Hold dec_ready=0 for 10 cycles in OUT -> dec_valid and dec_bit stable, sym_ready=0, a presented symbol is not accepted. Release dec_ready -> IDLE next cycle.
5. clear and sym_valid together in IDLE with fill=2 -> symbol not accepted, wr_ptr=0. The next 2 symbols produce no dec_valid.
6. Assert rst mid-TB (cycle 2) -> all outputs at reset values immediately. After release, the first symbol sweeps from acs_state=0 with wr_ptr=0.
